// File: rtl/cpu_test_pkg.sv
// Shared types and constants for the cpu run/check controller.
package cpu_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_CHECK,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_e;

  localparam int SIG_SUM    = 0;
  localparam int SIG_XOR    = 1;
  localparam int SIG_ROTXOR = 2;

  localparam logic [31:0] DEFAULT_TRAP_WORD = 32'h0000_000C;

endpackage

// File: rtl/sig_accum.sv
// Signature fold register: sum, XOR or rotate-left-1-then-XOR of a word stream.
module sig_accum
  import cpu_test_pkg::*;
#(
  parameter int W    = 32,
  parameter int MODE = SIG_SUM
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] sig_o,
  output logic [W-1:0] sig_next_o
);

  logic [W-1:0] sig_q;
  logic [W-1:0] fold;

  always_comb begin
    case (MODE)
      SIG_XOR:    fold = sig_q ^ data_i;
      SIG_ROTXOR: fold = {sig_q[W-2:0], sig_q[W-1]} ^ data_i;
      default:    fold = sig_q + data_i;
    endcase
    if (clr_i)     sig_next_o = '0;
    else if (en_i) sig_next_o = fold;
    else           sig_next_o = sig_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sig_q <= '0;
    else         sig_q <= sig_next_o;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/cpu_run_controller.sv
// Gates cpu execution, detects the trap word, drains, then folds a dmem window
// into a signature and reports pass, fail or timeout.
module cpu_run_controller
  import cpu_test_pkg::*;
#(
  parameter int              DATA_W       = 32,
  parameter int              ADDR_W       = 32,
  parameter int              MAX_CYCLES   = 10000,
  parameter logic [DATA_W-1:0] TRAP_WORD  = DATA_W'(DEFAULT_TRAP_WORD),
  parameter int              TRAP_REPEAT  = 2,
  parameter int              DRAIN_CYCLES = 5,
  parameter logic [ADDR_W-1:0] CHECK_BASE = '0,
  parameter int              CHECK_WORDS  = 8,
  parameter int              SIG_MODE     = SIG_SUM
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [DATA_W-1:0] inst_i,
  output logic              cpu_run_o,
  output logic              chk_rd_o,
  output logic [ADDR_W-1:0] chk_addr_o,
  input  logic [DATA_W-1:0] chk_rdata_i,
  input  logic [DATA_W-1:0] expected_sig_i,
  output logic [31:0]       cycle_count_o,
  output logic [DATA_W-1:0] signature_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

  state_e            state_q;
  logic [31:0]       cycle_q, trap_q, drain_q, idx_q;
  logic [31:0]       cycle_d, trap_d;
  logic              cpu_run_q, chk_rd_q, rd_vld_q, done_q, pass_q, timeout_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] exp_q;
  logic [DATA_W-1:0] sig_cur, sig_next;
  logic              sig_clr, sig_en;

  assign trap_d  = (inst_i == TRAP_WORD) ? trap_q + 32'd1 : 32'd0;
  assign cycle_d = (cycle_q == 32'hFFFF_FFFF) ? cycle_q : cycle_q + 32'd1;
  assign sig_clr = (state_q == ST_IDLE) && start_i;
  assign sig_en  = (state_q == ST_CHECK) && rd_vld_q;

  sig_accum #(
    .W    (DATA_W),
    .MODE (SIG_MODE)
  ) u_sig_accum (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (sig_clr),
    .en_i       (sig_en),
    .data_i     (chk_rdata_i),
    .sig_o      (sig_cur),
    .sig_next_o (sig_next)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cycle_q   <= '0;
      trap_q    <= '0;
      drain_q   <= '0;
      idx_q     <= '0;
      cpu_run_q <= 1'b0;
      chk_rd_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      addr_q    <= CHECK_BASE;
      exp_q     <= '0;
    end else begin
      rd_vld_q <= chk_rd_q;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q   <= ST_RUN;
            cpu_run_q <= 1'b1;
            cycle_q   <= '0;
            trap_q    <= '0;
          end
        end
        ST_RUN: begin
          cycle_q <= cycle_d;
          trap_q  <= trap_d;
          // Trap takes priority over a budget expiring on the same cycle.
          if (trap_d == 32'(TRAP_REPEAT)) begin
            cpu_run_q <= 1'b0;
            drain_q   <= '0;
            if (DRAIN_CYCLES == 0) begin
              state_q  <= ST_CHECK;
              chk_rd_q <= 1'b1;
              addr_q   <= CHECK_BASE;
              idx_q    <= '0;
              exp_q    <= expected_sig_i;
            end else begin
              state_q <= ST_DRAIN;
            end
          end else if (cycle_d == 32'(MAX_CYCLES)) begin
            cpu_run_q <= 1'b0;
            state_q   <= ST_TIMEOUT;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_q == 32'(DRAIN_CYCLES - 1)) begin
            state_q  <= ST_CHECK;
            chk_rd_q <= 1'b1;
            addr_q   <= CHECK_BASE;
            idx_q    <= '0;
            exp_q    <= expected_sig_i;
          end else begin
            drain_q <= drain_q + 32'd1;
          end
        end
        ST_CHECK: begin
          if (chk_rd_q) begin
            if (idx_q == 32'(CHECK_WORDS - 1)) begin
              chk_rd_q <= 1'b0;
            end else begin
              idx_q  <= idx_q + 32'd1;
              addr_q <= addr_q + STRIDE;
            end
          end
          // Last word is being folded this cycle: compare the folded value.
          if (rd_vld_q && !chk_rd_q) begin
            state_q <= (sig_next == exp_q) ? ST_PASS : ST_FAIL;
            done_q  <= 1'b1;
            pass_q  <= (sig_next == exp_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_run_o     = cpu_run_q;
  assign chk_rd_o      = chk_rd_q;
  assign chk_addr_o    = addr_q;
  assign cycle_count_o = cycle_q;
  assign signature_o   = sig_cur;
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench: a sum-mode and an xor-mode controller share one stimulus stream.
module tb_cpu_run_controller;
  import cpu_test_pkg::*;

  localparam logic [31:0] TRAP = 32'h0000_000C;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] inst = NOP;
  logic [31:0] exp_s, exp_x;
  logic [31:0] mem [0:7];

  logic        s_run, s_rd, s_done, s_pass, s_to;
  logic [31:0] s_addr, s_rdata, s_cc, s_sig;
  logic        x_run, x_rd, x_done, x_pass, x_to;
  logic [31:0] x_addr, x_rdata, x_cc, x_sig;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  cpu_run_controller #(.MAX_CYCLES(50), .SIG_MODE(SIG_SUM)) u_sum (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .inst_i(inst),
    .cpu_run_o(s_run), .chk_rd_o(s_rd), .chk_addr_o(s_addr), .chk_rdata_i(s_rdata),
    .expected_sig_i(exp_s), .cycle_count_o(s_cc), .signature_o(s_sig),
    .done_o(s_done), .pass_o(s_pass), .timeout_o(s_to)
  );

  cpu_run_controller #(.MAX_CYCLES(50), .SIG_MODE(SIG_XOR)) u_xor (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .inst_i(inst),
    .cpu_run_o(x_run), .chk_rd_o(x_rd), .chk_addr_o(x_addr), .chk_rdata_i(x_rdata),
    .expected_sig_i(exp_x), .cycle_count_o(x_cc), .signature_o(x_sig),
    .done_o(x_done), .pass_o(x_pass), .timeout_o(x_to)
  );

  // dmem model: one-cycle read latency, word i holds i+1
  always @(posedge clk) begin
    s_rdata <= s_rd ? mem[s_addr[4:2]] : 32'h0;
    x_rdata <= x_rd ? mem[x_addr[4:2]] : 32'h0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    inst  = NOP;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_run(input int n, input int t0, input int t1);
    for (int k = 1; k <= n; k++) begin
      inst = (k >= t0 && k <= t1) ? TRAP : NOP;
      tick();
    end
    inst = NOP;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({s_run, s_rd, s_done, s_pass, s_to, x_run, x_rd, x_done, x_pass, x_to} !== 10'b0) begin
      err_cnt++;
      $display("FAIL reset_flags: got %b want 0",
               {s_run, s_rd, s_done, s_pass, s_to, x_run, x_rd, x_done, x_pass, x_to});
    end
    vec_cnt++;
    if ({s_addr, s_cc, s_sig} !== 96'h0) begin
      err_cnt++;
      $display("FAIL reset_values: addr %0h cc %0d sig %0h want 0", s_addr, s_cc, s_sig);
    end
    tick();
    rst_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_trap_path();
    int n;
    exp_s = 32'd36;
    exp_x = 32'd9;
    do_reset();
    start_pulse();
    for (int k = 1; k <= 21; k++) begin
      inst = (k >= 20) ? TRAP : NOP;
      vec_cnt++;
      if ({s_run, x_run} !== 2'b11) begin
        err_cnt++;
        $display("FAIL run_enable: cycle %0d got %b want 11", k, {s_run, x_run});
      end
      tick();
    end
    inst = NOP;
    vec_cnt++;
    if ({s_run, x_run} !== 2'b00) begin
      err_cnt++;
      $display("FAIL run_drop: got %b want 00", {s_run, x_run});
    end
    vec_cnt++;
    if (s_cc !== 32'd21 || x_cc !== 32'd21) begin
      err_cnt++;
      $display("FAIL trap_cycle_count: got %0d/%0d want 21", s_cc, x_cc);
    end
    n = 0;
    while (!s_rd && n < 20) begin
      tick();
      n++;
    end
    vec_cnt++;
    if (n !== 5) begin
      err_cnt++;
      $display("FAIL drain_length: got %0d want 5", n);
    end
    // expected_sig must already be latched; later changes are irrelevant
    exp_s = 32'hDEAD_BEEF;
    exp_x = 32'd8;
    for (int i = 0; i < 8; i++) begin
      vec_cnt++;
      if (s_rd !== 1'b1 || x_rd !== 1'b1 || s_addr !== 32'(4 * i) || x_addr !== 32'(4 * i)) begin
        err_cnt++;
        $display("FAIL check_read %0d: rd %b addr %0h want rd 1 addr %0h", i, s_rd, s_addr, 4 * i);
      end
      tick();
    end
    vec_cnt++;
    if ({s_rd, x_rd, s_done} !== 3'b000) begin
      err_cnt++;
      $display("FAIL reads_end: rd/done got %b want 000", {s_rd, x_rd, s_done});
    end
    tick();
    vec_cnt++;
    if ({s_done, s_pass, s_to} !== 3'b110 || s_sig !== 32'd36) begin
      err_cnt++;
      $display("FAIL sum_pass: d/p/t %b sig %0d want 110 sig 36", {s_done, s_pass, s_to}, s_sig);
    end
    vec_cnt++;
    if ({x_done, x_pass, x_to} !== 3'b100 || x_sig !== 32'd8) begin
      err_cnt++;
      $display("FAIL xor_fail: d/p/t %b sig %0d want 100 sig 8", {x_done, x_pass, x_to}, x_sig);
    end
    start_pulse();
    tick();
    vec_cnt++;
    if ({s_done, s_pass, s_run, x_done, x_pass, x_run} !== 6'b110100 || s_cc !== 32'd21) begin
      err_cnt++;
      $display("FAIL terminal_hold: got %b cc %0d want 110100 cc 21",
               {s_done, s_pass, s_run, x_done, x_pass, x_run}, s_cc);
    end
    $display("test_trap_path done");
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    start_pulse();
    n = 0;
    while (!s_to && n < 60) begin
      tick();
      n++;
    end
    vec_cnt++;
    if (n !== 50 || s_cc !== 32'd50) begin
      err_cnt++;
      $display("FAIL timeout_cycles: got %0d cc %0d want 50", n, s_cc);
    end
    vec_cnt++;
    if ({s_done, s_pass, s_run, x_to, x_done} !== 5'b10011) begin
      err_cnt++;
      $display("FAIL timeout_flags: got %b want 10011", {s_done, s_pass, s_run, x_to, x_done});
    end
    $display("test_timeout done");
  endtask

  task automatic test_trap_priority();
    int n;
    exp_s = 32'd36;
    exp_x = 32'd8;
    do_reset();
    start_pulse();
    drive_run(50, 49, 50);
    vec_cnt++;
    if ({s_to, s_run, s_done} !== 3'b000 || s_cc !== 32'd50) begin
      err_cnt++;
      $display("FAIL trap_priority: t/r/d %b cc %0d want 000 cc 50", {s_to, s_run, s_done}, s_cc);
    end
    n = 0;
    while (!(s_done && x_done) && n < 40) begin
      tick();
      n++;
    end
    vec_cnt++;
    if ({s_pass, s_to, x_pass, x_to} !== 4'b1010) begin
      err_cnt++;
      $display("FAIL priority_result: got %b want 1010", {s_pass, s_to, x_pass, x_to});
    end
    $display("test_trap_priority done");
  endtask

  task automatic test_glitch();
    do_reset();
    start_pulse();
    for (int k = 1; k <= 30; k++) begin
      inst = (k == 10 || k == 15 || k == 24) ? TRAP : NOP;
      tick();
    end
    inst = NOP;
    vec_cnt++;
    if ({s_run, x_run, s_done, s_rd} !== 4'b1100 || s_cc !== 32'd30) begin
      err_cnt++;
      $display("FAIL glitch_trap: r/r/d/rd %b cc %0d want 1100 cc 30", {s_run, x_run, s_done, s_rd}, s_cc);
    end
    $display("test_glitch done");
  endtask

  task automatic test_abort();
    int n;
    exp_s = 32'd36;
    exp_x = 32'd8;
    do_reset();
    start_pulse();
    drive_run(21, 20, 21);
    n = 0;
    while (!s_rd && n < 20) begin
      tick();
      n++;
    end
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({s_run, s_rd, s_done, s_pass, s_to} !== 5'b0 || s_addr !== 32'h0 || s_cc !== 32'h0 || s_sig !== 32'h0) begin
      err_cnt++;
      $display("FAIL abort_reset: flags %b addr %0h cc %0d sig %0h want all 0",
               {s_run, s_rd, s_done, s_pass, s_to}, s_addr, s_cc, s_sig);
    end
    tick();
    rst_n = 1'b1;
    tick();
    start_pulse();
    drive_run(21, 20, 21);
    n = 0;
    while (!(s_done && x_done) && n < 40) begin
      tick();
      n++;
    end
    vec_cnt++;
    if ({s_pass, x_pass, s_to} !== 3'b110 || s_sig !== 32'd36 || x_sig !== 32'd8 || s_cc !== 32'd21) begin
      err_cnt++;
      $display("FAIL rerun: p/p/t %b sig %0d/%0d cc %0d want 110 36/8 cc 21",
               {s_pass, x_pass, s_to}, s_sig, x_sig, s_cc);
    end
    $display("test_abort done");
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'(i + 1);
    exp_s = 32'd36;
    exp_x = 32'd9;
    test_reset();
    test_trap_path();
    test_timeout();
    test_trap_priority();
    test_glitch();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Parametrised run/check controller placed between a processor test harness and the cpu under test.
- Gates cpu execution and enforces a cycle budget.
- Detects program end by a trap instruction word, waits for the pipeline to drain, then walks a data-memory window and folds it into a signature.
- Flags pass, fail or timeout. It replaces fixed-delay $finish runs with deterministic end-of-test detection.

Parameters:
DATA_W, 32, width of instruction word, dmem word and signature
ADDR_W, 32, dmem byte-address width
MAX_CYCLES, 10000, cycle budget in RUN before timeout (≥1)
TRAP_WORD, 32'h0000_000C, instruction word that marks program end
TRAP_REPEAT, 2, consecutive cycles TRAP_WORD must be seen (≥1)
DRAIN_CYCLES, 5, cycles waited after trap before checking (≥0)
CHECK_BASE, 0, first dmem byte address checked
CHECK_WORDS, 8, words checked (≥1); stride DATA_W/8 bytes
SIG_MODE, 0, 0 = sum mod 2^DATA_W, 1 = XOR fold, 2 = rotate-left-1 then XOR

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE
inst  in  DATA_W  instruction currently fetched by cpu
cpu_run  out  1  execution enable to cpu; high only in RUN
chk_rd  out  1  dmem read strobe
chk_addr  out  ADDR_W  dmem read address
chk_rdata  in  DATA_W  dmem read data, valid 1 cycle after chk_rd
expected_sig  in  DATA_W  golden signature; sampled on entry to CHECK
cycle_count  out  32  cycles spent in RUN, frozen after RUN
signature  out  DATA_W  running/final signature
done  out  1  high in PASS, FAIL or TIMEOUT
pass  out  1  high only in PASS
timeout  out  1  high only in TIMEOUT

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE; cpu_run, chk_rd, done, pass and timeout all 0; chk_addr=CHECK_BASE; cycle_count=0; signature=0. An rst_n assertion in any state aborts immediately to these values.
- States are IDLE, RUN, DRAIN, CHECK, PASS, FAIL, TIMEOUT.
- IDLE:
  - start=1 → RUN next cycle.
  - cycle_count, signature and the trap counter clear on the same edge.
- RUN:
  - cpu_run=1 and cycle_count increments every cycle.
  - Trap counter increments when inst==TRAP_WORD and resets to 0 otherwise.
  - Trap counter reaching TRAP_REPEAT → DRAIN, with cpu_run deasserting on that edge.
  - Otherwise cycle_count reaching MAX_CYCLES → TIMEOUT.
  - If both occur on the same cycle, trap wins.
  - cycle_count saturates at 2^32-1.
- DRAIN:
  - cpu_run=0; counts DRAIN_CYCLES cycles, then → CHECK.
  - DRAIN_CYCLES=0 goes directly to CHECK on the next edge.
- CHECK:
  - Issues CHECK_WORDS reads on consecutive cycles: chk_rd=1, chk_addr=CHECK_BASE+i*(DATA_W/8).
  - Each chk_rdata is folded into signature one cycle after its read; fold is per SIG_MODE, with sum wrapping mod 2^DATA_W.
  - After the last word folds (CHECK_WORDS+1 cycles in CHECK), compare signature against the latched expected_sig: equal → PASS, else FAIL.
  - Address increment wraps mod 2^ADDR_W.
- PASS, FAIL, TIMEOUT:
  - Terminal states; done=1. pass=1 only in PASS; timeout=1 only in TIMEOUT.
  - Outputs hold until reset; start is ignored.
- start pulses outside IDLE are ignored.
- All outputs are registered (no combinational input→output paths).

Decomposition:
- Shared package cpu_test_pkg holds:
  - state enum
  - SIG_MODE constants (SIG_SUM, SIG_XOR, SIG_ROTXOR)
  - default TRAP_WORD
- One natural sub-module: sig_accum, the signature fold register with a mode parameter, clear and enable.

Test Plan:
- Setup for all scenarios: reset, start pulse, inst stream with TRAP_WORD appearing at RUN cycle 20 and held 2 cycles.
- Trap path: stream above → cpu_run low after cycle 21; cycle_count=21; DRAIN lasts 5 cycles; 8 chk_rd pulses at addresses 0,4,…,28.
- Sum PASS: dmem words 1..8, expected_sig=36, SIG_MODE=0 → pass=1, done=1, signature=36.
- XOR FAIL: SIG_MODE=1, dmem words 1..8 (XOR=8), expected_sig=9 → done=1, pass=0, timeout=0, signature=8.
- Timeout and trap priority:
  - No trap, MAX_CYCLES=50 → timeout=1 with cycle_count=50.
  - Separately, trap completing exactly at cycle 50 → DRAIN, not TIMEOUT.
- Glitch and abort:
  - Single-cycle TRAP_WORD followed by another word → trap counter resets, RUN continues.
  - rst_n dropped mid-CHECK → all outputs at reset values asynchronously; a fresh start re-runs cleanly.
